// File: rtl/stack_memory_unit.sv
// Single-port data RAM with a built-in downward-growing stack pointer, registered
// read data with a one-cycle valid strobe, and sticky overflow/underflow flags.
module stack_memory_unit #(
  parameter int WIDTH   = 16,
  parameter int ADDR_W  = 10,
  parameter int SP_INIT = (2**ADDR_W) - 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] PC,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] A,
  input  logic             ClrErr,
  output logic [WIDTH-1:0] MD,
  output logic             MDValid,
  output logic [WIDTH-1:0] SP,
  output logic             Overflow,
  output logic             Underflow
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] SP_RST = ADDR_W'(SP_INIT);

  typedef enum logic [2:0] {
    OP_IDLE  = 3'b000,
    OP_FETCH = 3'b001,
    OP_LOAD  = 3'b010,
    OP_STORE = 3'b011,
    OP_PUSH  = 3'b100,
    OP_POP   = 3'b101,
    OP_PEEK  = 3'b110,
    OP_SETSP = 3'b111
  } op_e;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] sp_q, sp_d, sp_inc;
  logic [WIDTH-1:0]  md_q;
  logic              md_valid_q, md_valid_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              we, rd_en;
  logic [ADDR_W-1:0] waddr, raddr;
  logic              stack_full, stack_empty;

  // Upper address bits are intentionally dropped; addresses wrap modulo DEPTH.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{PC, B};

  assign sp_inc      = sp_q + ADDR_W'(1);
  assign stack_full  = (sp_q == '0);
  assign stack_empty = (sp_q == '1);

  always_comb begin
    sp_d       = sp_q;
    md_valid_d = 1'b0;
    ovf_d      = ovf_q & ~ClrErr;
    unf_d      = unf_q & ~ClrErr;
    we         = 1'b0;
    waddr      = B[ADDR_W-1:0];
    rd_en      = 1'b0;
    raddr      = B[ADDR_W-1:0];
    case (op_e'(Op))
      OP_FETCH: begin
        rd_en      = 1'b1;
        raddr      = PC[ADDR_W-1:0];
        md_valid_d = 1'b1;
      end
      OP_LOAD: begin
        rd_en      = 1'b1;
        md_valid_d = 1'b1;
      end
      OP_STORE: we = 1'b1;
      OP_PUSH: begin
        if (stack_full) begin
          ovf_d = 1'b1;
        end else begin
          we    = 1'b1;
          waddr = sp_q;
          sp_d  = sp_q - ADDR_W'(1);
        end
      end
      OP_POP, OP_PEEK: begin
        // A new error wins over a simultaneous ClrErr.
        if (stack_empty) begin
          unf_d = 1'b1;
        end else begin
          rd_en      = 1'b1;
          raddr      = sp_inc;
          md_valid_d = 1'b1;
          if (op_e'(Op) == OP_POP) sp_d = sp_inc;
        end
      end
      OP_SETSP: sp_d = B[ADDR_W-1:0];
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sp_q       <= SP_RST;
      md_q       <= '0;
      md_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      sp_q       <= sp_d;
      md_valid_q <= md_valid_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      if (rd_en) md_q <= mem_q[raddr];
    end
  end

  // RAM has no reset; a write presented during reset is discarded.
  always_ff @(posedge CLK) begin
    if (!RST && we) mem_q[waddr] <= A;
  end

  // MDValid is a one-cycle strobe: MD carries fresh read data exactly when it is high.
  assign MD        = md_q;
  assign MDValid   = md_valid_q;
  assign SP        = WIDTH'(sp_q);
  assign Overflow  = ovf_q;
  assign Underflow = unf_q;

endmodule

// File: tb/tb_stack_memory_unit.sv
// Directed bench for stack_memory_unit (WIDTH=16, ADDR_W=4): reset, store/load,
// stack LIFO, underflow/overflow flags and fetch-vs-load address selection.
module tb_stack_memory_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic [2:0]  Op;
  logic [15:0] PC, B, A;
  logic        ClrErr;
  logic [15:0] MD, SP;
  logic        MDValid, Overflow, Underflow;

  int pass_cnt  = 0;
  int total_cnt = 0;

  localparam logic [2:0] IDLE = 3'b000, FETCH = 3'b001, LOAD = 3'b010, STORE = 3'b011,
                         PUSH = 3'b100, POP = 3'b101, PEEK = 3'b110, SETSP = 3'b111;

  stack_memory_unit #(.WIDTH(16), .ADDR_W(4), .SP_INIT(15)) dut (
    .CLK(CLK), .RST(RST), .Op(Op), .PC(PC), .B(B), .A(A), .ClrErr(ClrErr),
    .MD(MD), .MDValid(MDValid), .SP(SP), .Overflow(Overflow), .Underflow(Underflow)
  );

  always #5 CLK = ~CLK;

  // Present one op, let it execute on the rising edge, then settle before checks.
  task automatic do_op(input logic [2:0] op, input logic [15:0] pc, input logic [15:0] b,
                       input logic [15:0] a, input logic clr);
    Op = op; PC = pc; B = b; A = a; ClrErr = clr;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    RST = 1'b1; Op = STORE; PC = '0; B = 16'd3; A = 16'hBEEF; ClrErr = 1'b0;
    @(posedge CLK); @(posedge CLK); #1;
    check("rst_sp", SP, 16'd15);
    check("rst_md", MD, 16'h0000);
    check("rst_mdvalid", {15'b0, MDValid}, 16'd0);
    check("rst_ovf", {15'b0, Overflow}, 16'd0);
    check("rst_unf", {15'b0, Underflow}, 16'd0);
    RST = 1'b0;
    do_op(LOAD, 16'd0, 16'd3, 16'd0, 1'b0);
    check("rst_no_write", {15'b0, (MD !== 16'hBEEF)}, 16'd1);
    check("rst_load_valid", {15'b0, MDValid}, 16'd1);

    // Store/load, including address wrap on B.
    do_op(STORE, 16'd0, 16'd1, 16'h0022, 1'b0);
    check("store_mdvalid", {15'b0, MDValid}, 16'd0);
    do_op(LOAD, 16'd0, 16'd1, 16'd0, 1'b0);
    check("load1_md", MD, 16'h0022);
    check("load1_valid", {15'b0, MDValid}, 16'd1);
    do_op(STORE, 16'd0, 16'h00F3, 16'h0744, 1'b0);
    do_op(LOAD, 16'd0, 16'd3, 16'd0, 1'b0);
    check("load_wrap_md", MD, 16'h0744);

    // Stack LIFO.
    do_op(PUSH, 16'd0, 16'd0, 16'h1111, 1'b0);
    check("push1_sp", SP, 16'd14);
    do_op(PUSH, 16'd0, 16'd0, 16'h2222, 1'b0);
    do_op(PUSH, 16'd0, 16'd0, 16'h3333, 1'b0);
    check("push3_sp", SP, 16'd12);
    check("push_md_hold", MD, 16'h0744);
    check("push_mdvalid", {15'b0, MDValid}, 16'd0);
    do_op(PEEK, 16'd0, 16'd0, 16'd0, 1'b0);
    check("peek_md", MD, 16'h3333);
    check("peek_sp", SP, 16'd12);
    check("peek_valid", {15'b0, MDValid}, 16'd1);
    do_op(POP, 16'd0, 16'd0, 16'd0, 1'b0);
    check("pop1_md", MD, 16'h3333);
    check("pop1_valid", {15'b0, MDValid}, 16'd1);
    do_op(POP, 16'd0, 16'd0, 16'd0, 1'b0);
    check("pop2_md", MD, 16'h2222);
    check("pop2_valid", {15'b0, MDValid}, 16'd1);
    do_op(POP, 16'd0, 16'd0, 16'd0, 1'b0);
    check("pop3_md", MD, 16'h1111);
    check("pop3_valid", {15'b0, MDValid}, 16'd1);
    check("pop3_sp", SP, 16'd15);

    // Underflow and ClrErr priority.
    do_op(POP, 16'd0, 16'd0, 16'd0, 1'b0);
    check("unf_flag", {15'b0, Underflow}, 16'd1);
    check("unf_mdvalid", {15'b0, MDValid}, 16'd0);
    check("unf_md_hold", MD, 16'h1111);
    check("unf_sp", SP, 16'd15);
    do_op(POP, 16'd0, 16'd0, 16'd0, 1'b1);
    check("unf_set_wins", {15'b0, Underflow}, 16'd1);
    do_op(IDLE, 16'd0, 16'd0, 16'd0, 1'b1);
    check("unf_cleared", {15'b0, Underflow}, 16'd0);

    // Overflow: push on full stack must not disturb mem[0].
    do_op(STORE, 16'd0, 16'd0, 16'h1234, 1'b0);
    do_op(SETSP, 16'd0, 16'd0, 16'd0, 1'b0);
    check("setsp0_sp", SP, 16'd0);
    do_op(PUSH, 16'd0, 16'd0, 16'hFF00, 1'b0);
    check("ovf_flag", {15'b0, Overflow}, 16'd1);
    check("ovf_sp", SP, 16'd0);
    do_op(LOAD, 16'd0, 16'd0, 16'd0, 1'b0);
    check("ovf_mem0", MD, 16'h1234);
    do_op(SETSP, 16'd0, 16'd1, 16'd0, 1'b0);
    check("setsp1_sp", SP, 16'd1);
    check("setsp_keeps_ovf", {15'b0, Overflow}, 16'd1);
    do_op(PUSH, 16'd0, 16'd0, 16'hFF00, 1'b0);
    check("push_last_sp", SP, 16'd0);
    do_op(LOAD, 16'd0, 16'd1, 16'd0, 1'b0);
    check("push_last_mem1", MD, 16'hFF00);

    // Fetch uses PC, load uses B.
    do_op(STORE, 16'd0, 16'd5, 16'hAAAA, 1'b0);
    do_op(STORE, 16'd0, 16'd6, 16'h5555, 1'b0);
    do_op(FETCH, 16'd5, 16'd6, 16'd0, 1'b0);
    check("fetch_md", MD, 16'hAAAA);
    check("fetch_valid", {15'b0, MDValid}, 16'd1);
    do_op(LOAD, 16'd5, 16'd6, 16'd0, 1'b0);
    check("load_md", MD, 16'h5555);
    do_op(IDLE, 16'd0, 16'd0, 16'd0, 1'b0);
    check("idle_mdvalid", {15'b0, MDValid}, 16'd0);

    // Mid-run reset clears flags and restores SP.
    RST = 1'b1;
    do_op(PUSH, 16'd0, 16'd0, 16'h9999, 1'b0);
    RST = 1'b0;
    check("rst2_sp", SP, 16'd15);
    check("rst2_ovf", {15'b0, Overflow}, 16'd0);
    check("rst2_md", MD, 16'h0000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
